// File: rtl/clk_pkg.sv
`default_nettype none
// ============================================================================
// Module      : clk_pkg
// Description : Shared types, defaults and config legality check for the
//               programmable clock/tick divider.
// Revision    : 1.0 - initial release
// ============================================================================
package clk_pkg;

  // Default counter / field width
  localparam int unsigned CLK_WIDTH = 32;

  // Controller state encoding
  typedef enum logic [0:0] {
    ST_IDLE = 1'b0,
    ST_RUN  = 1'b1
  } state_e;

  // A period needs at least two cycles and the high time cannot exceed it.
  // Arguments are widened so the check works for any field width.
  function automatic logic cfg_legal(input logic [63:0] div, input logic [63:0] high);
    return (div >= 64'd2) && (high <= div);
  endfunction

endpackage
`default_nettype wire

// File: rtl/clk_div_core.sv
`default_nettype none
// ============================================================================
// Module      : clk_div_core
// Description : Period counter with active period/high-time registers.
//               Outputs are flops loaded from next-state values, so clk_out
//               and tick in a cycle reflect that same cycle's counter.
// Revision    : 1.0 - initial release
// ============================================================================
module clk_div_core
  import clk_pkg::*;
#(
  parameter int unsigned      WIDTH        = CLK_WIDTH,
  parameter logic [WIDTH-1:0] DEFAULT_DIV  = WIDTH'(12000000),
  parameter logic [WIDTH-1:0] DEFAULT_HIGH = DEFAULT_DIV >> 1
) (
  input  logic             clk_in,
  input  logic             rst_n,
  input  logic             active_i,   // currently in RUN
  input  logic             run_i,      // RUN in the next cycle
  input  logic             load_i,     // take div_i/high_i as the next active values
  input  logic [WIDTH-1:0] div_i,
  input  logic [WIDTH-1:0] high_i,
  output logic             clk_out_o,
  output logic             tick_o,
  output logic             wrap_o
);

  logic [WIDTH-1:0] counter_q, counter_d;
  logic [WIDTH-1:0] div_q, div_d;
  logic [WIDTH-1:0] high_q, high_d;
  logic             clk_q, clk_d;
  logic             tick_q, tick_d;

  assign wrap_o    = active_i && (counter_q == (div_q - WIDTH'(1)));
  assign clk_out_o = clk_q;
  assign tick_o    = tick_q;

  // Next-state: count while running, park at zero otherwise; outputs are
  // pre-computed from the next counter and next active settings.
  always_comb begin
    div_d     = load_i ? div_i  : div_q;
    high_d    = load_i ? high_i : high_q;
    counter_d = (active_i && run_i && !wrap_o) ? (counter_q + WIDTH'(1)) : '0;
    clk_d     = run_i && (counter_d < high_d);
    tick_d    = run_i && (counter_d == (div_d - WIDTH'(1)));
  end

  // State and output flops
  always_ff @(posedge clk_in or negedge rst_n) begin
    if (!rst_n) begin
      counter_q <= '0;
      div_q     <= DEFAULT_DIV;
      high_q    <= DEFAULT_HIGH;
      clk_q     <= 1'b0;
      tick_q    <= 1'b0;
    end else begin
      counter_q <= counter_d;
      div_q     <= div_d;
      high_q    <= high_d;
      clk_q     <= clk_d;
      tick_q    <= tick_d;
    end
  end

endmodule
`default_nettype wire

// File: rtl/clk_div_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : clk_div_ctrl
// Description : Runtime-programmable clock/tick generator. New period and
//               high time arrive over a valid/ready port, are checked, held
//               in a shadow and applied only at a period boundary (or while
//               idle) so clk_out never glitches.
// Revision    : 1.0 - initial release
// ============================================================================
module clk_div_ctrl
  import clk_pkg::*;
#(
  parameter int unsigned      WIDTH        = CLK_WIDTH,
  parameter logic [WIDTH-1:0] DEFAULT_DIV  = WIDTH'(12000000),
  parameter logic [WIDTH-1:0] DEFAULT_HIGH = DEFAULT_DIV >> 1
) (
  input  logic             clk_in,
  input  logic             rst_n,
  input  logic             en,
  input  logic             cfg_valid,
  output logic             cfg_ready,
  input  logic [WIDTH-1:0] cfg_div,
  input  logic [WIDTH-1:0] cfg_high,
  output logic             cfg_err,
  output logic             pending,
  output logic             clk_out,
  output logic             tick
);

  state_e           state_q;
  logic             pending_q;
  logic             err_q;
  logic [WIDTH-1:0] div_sh_q;
  logic [WIDTH-1:0] high_sh_q;

  logic w_cfg_fire;
  logic w_cfg_legal;
  logic w_wrap;
  logic w_apply;

  assign w_cfg_fire  = cfg_valid && cfg_ready;
  assign w_cfg_legal = cfg_legal(64'(cfg_div), 64'(cfg_high));
  // Shadow goes live at a wrap while running, or immediately when idle.
  // pending_q is still low in the acceptance cycle, so a config accepted on
  // a wrap waits for the following wrap.
  assign w_apply     = pending_q && ((state_q == ST_IDLE) || w_wrap);

  assign cfg_ready = !pending_q;
  assign cfg_err   = err_q;
  assign pending   = pending_q;

  // FSM, handshake and shadow registers
  always_ff @(posedge clk_in or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= ST_IDLE;
      pending_q <= 1'b0;
      err_q     <= 1'b0;
      div_sh_q  <= '0;
      high_sh_q <= '0;
    end else begin
      state_q <= en ? ST_RUN : ST_IDLE;
      err_q   <= w_cfg_fire && !w_cfg_legal;
      if (w_cfg_fire && w_cfg_legal) begin
        pending_q <= 1'b1;
        div_sh_q  <= cfg_div;
        high_sh_q <= cfg_high;
      end else if (w_apply) begin
        pending_q <= 1'b0;
      end
    end
  end

  clk_div_core #(
    .WIDTH        (WIDTH),
    .DEFAULT_DIV  (DEFAULT_DIV),
    .DEFAULT_HIGH (DEFAULT_HIGH)
  ) u_core (
    .clk_in    (clk_in),
    .rst_n     (rst_n),
    .active_i  (state_q == ST_RUN),
    .run_i     (en),
    .load_i    (w_apply),
    .div_i     (div_sh_q),
    .high_i    (high_sh_q),
    .clk_out_o (clk_out),
    .tick_o    (tick),
    .wrap_o    (w_wrap)
  );

endmodule
`default_nettype wire

// File: tb/tb_clk_div_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_clk_div_ctrl
// Description : Directed scoreboard bench for clk_div_ctrl. The stimulus
//               thread pushes the hand-derived outputs expected for each
//               cycle; a monitor pops and compares mid-cycle.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_clk_div_ctrl;

  logic        clk_in = 1'b0;
  logic        rst_n;
  logic        en;
  logic        cfg_valid;
  logic        cfg_ready;
  logic [31:0] cfg_div;
  logic [31:0] cfg_high;
  logic        cfg_err;
  logic        pending;
  logic        clk_out;
  logic        tick;

  typedef struct packed {
    logic c;   // clk_out
    logic t;   // tick
    logic p;   // pending
    logic r;   // cfg_ready
    logic e;   // cfg_err
  } exp_t;

  exp_t exp_q[$];
  exp_t mon_exp;
  exp_t mon_act;
  int   checks = 0;
  int   errors = 0;
  int   cyc_n  = 0;

  clk_div_ctrl #(
    .WIDTH        (32),
    .DEFAULT_DIV  (32'd10),
    .DEFAULT_HIGH (32'd5)
  ) dut (
    .clk_in    (clk_in),
    .rst_n     (rst_n),
    .en        (en),
    .cfg_valid (cfg_valid),
    .cfg_ready (cfg_ready),
    .cfg_div   (cfg_div),
    .cfg_high  (cfg_high),
    .cfg_err   (cfg_err),
    .pending   (pending),
    .clk_out   (clk_out),
    .tick      (tick)
  );

  always #5 clk_in = ~clk_in;

  // Wait for the next negedge and record what this cycle must show.
  task automatic cyc(input logic c, input logic t, input logic p, input logic e);
    @(negedge clk_in);
    exp_q.push_back('{c: c, t: t, p: p, r: ~p, e: e});
  endtask

  // Phases lo..hi of a period with the given active div/high.
  task automatic seg(input int div, input int high, input int lo, input int hi, input logic p);
    for (int i = lo; i <= hi; i++) cyc(i < high, i == div - 1, p, 1'b0);
  endtask

  task automatic offer(input int d, input int h);
    cfg_valid = 1'b1;
    cfg_div   = d;
    cfg_high  = h;
  endtask

  // Monitor: compare every cycle that has a pushed expectation
  initial begin
    forever begin
      @(negedge clk_in);
      #1;
      cyc_n++;
      if (exp_q.size() != 0) begin
        mon_exp = exp_q.pop_front();
        mon_act = '{c: clk_out, t: tick, p: pending, r: cfg_ready, e: cfg_err};
        checks++;
        if (mon_act !== mon_exp) begin
          errors++;
          $display("FAIL cycle %0d outputs{clk,tick,pend,rdy,err}: got %b required %b",
                   cyc_n, mon_act, mon_exp);
        end
      end
    end
  end

  // Watchdog
  initial begin
    #200000;
    $display("FAIL watchdog: bench did not complete in time");
    $fatal(1);
  end

  // Stimulus
  initial begin
    rst_n     = 1'b1;
    en        = 1'b0;
    cfg_valid = 1'b0;
    cfg_div   = '0;
    cfg_high  = '0;
    #1 rst_n  = 1'b0;

    // Reset state
    cyc(0, 0, 0, 0);
    cyc(0, 0, 0, 0);
    rst_n = 1'b1;
    en    = 1'b1;

    // Default 10/5 waveform
    seg(10, 5, 0, 9, 0);
    seg(10, 5, 0, 9, 0);

    // Load 4/1 at counter 3: current period finishes unchanged
    seg(10, 5, 0, 3, 0);
    offer(4, 1);
    seg(10, 5, 4, 4, 1);
    cfg_valid = 1'b0;
    seg(10, 5, 5, 9, 1);
    seg(4, 1, 0, 3, 0);
    seg(4, 1, 0, 3, 0);

    // Illegal div = 1
    seg(4, 1, 0, 0, 0);
    offer(1, 0);
    cyc(0, 0, 0, 1);
    cfg_valid = 1'b0;
    seg(4, 1, 2, 3, 0);
    // Illegal high 7 > div 6
    seg(4, 1, 0, 0, 0);
    offer(6, 7);
    cyc(0, 0, 0, 1);
    cfg_valid = 1'b0;
    seg(4, 1, 2, 3, 0);
    seg(4, 1, 0, 3, 0);

    // Accept 6/3 on the wrap cycle: old period repeats once more
    seg(4, 1, 0, 3, 0);
    offer(6, 3);
    seg(4, 1, 0, 0, 1);
    cfg_valid = 1'b0;
    seg(4, 1, 1, 3, 1);
    seg(6, 3, 0, 5, 0);

    // Offer 8/8 then drop en mid-high while pending
    seg(6, 3, 0, 0, 0);
    offer(8, 8);
    cyc(1, 0, 1, 0);
    cfg_valid = 1'b0;
    en        = 1'b0;
    cyc(0, 0, 1, 0);      // IDLE, shadow applied at end of this cycle
    cyc(0, 0, 0, 0);      // IDLE, applied
    en = 1'b1;
    // high == div: constant high, tick still runs
    seg(8, 8, 0, 7, 0);
    seg(8, 8, 0, 0, 0);
    offer(3, 0);
    seg(8, 8, 1, 1, 1);
    cfg_valid = 1'b0;
    seg(8, 8, 2, 7, 1);
    // high == 0: constant low, tick still runs
    seg(3, 0, 0, 2, 0);
    seg(3, 0, 0, 2, 0);

    // Reset mid-period with a config pending
    seg(3, 0, 0, 0, 0);
    offer(5, 2);
    cyc(0, 0, 1, 0);
    cfg_valid = 1'b0;
    @(posedge clk_in);
    #2 rst_n = 1'b0;
    cyc(0, 0, 0, 0);
    cyc(0, 0, 0, 0);
    rst_n = 1'b1;
    seg(10, 5, 0, 9, 0);
    seg(10, 5, 0, 9, 0);

    // Drain the scoreboard
    repeat (3) @(negedge clk_in);
    #2;
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL drain: %0d expectations left, required 0", exp_q.size());
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/clk_div_ctrl.md
Name: clk_div_ctrl

Overview:
- Runtime-programmable clock/tick generator for the i2cpwm design on iCESugar-nano.
- Replaces fixed compile-time divide with a sequenced divider. Period and high time are loaded through a valid/ready config port and applied only at a period boundary, so clk_out never glitches or shows a runt pulse.
- Feeds the I2C bit-rate and PWM timebases; a one-cycle tick marks each period end for downstream enables.

Parameters:
- WIDTH, 32, width of the counter, period and high-time fields.
- DEFAULT_DIV, 12000000, period in clk_in cycles after reset.
- DEFAULT_HIGH, DEFAULT_DIV/2, high time in clk_in cycles after reset.

Ports:
- clk_in  input  1  system clock; single clock domain.
- rst_n  input  1  asynchronous, active-low reset.
- en  input  1  run enable; low = output held low, counter parked.
- cfg_valid  input  1  config offer.
- cfg_ready  output  1  config port can accept.
- cfg_div  input  WIDTH  requested period in clk_in cycles.
- cfg_high  input  WIDTH  requested high time in clk_in cycles.
- cfg_err  output  1  one-cycle pulse: offered config rejected.
- pending  output  1  accepted config awaiting application.
- clk_out  output  1  divided clock, driven straight from a flop.
- tick  output  1  one-cycle pulse in last cycle of each period.

Behaviour:
- Reset (async assert, sync release):
  - counter = 0, div_act = DEFAULT_DIV, high_act = DEFAULT_HIGH.
  - State IDLE, clk_out = 0, tick = 0, cfg_err = 0, pending = 0, cfg_ready = 1.
  - Any shadow config is discarded.
- States:
  - IDLE: en = 0. counter = 0, clk_out = 0, tick = 0.
  - RUN: counter counts 0..div_act-1, then wraps to 0.
- Transitions:
  - IDLE -> RUN when en = 1; first RUN cycle has counter = 0.
  - RUN -> IDLE when en = 0; takes effect next cycle, and clk_out falls there even mid-high.
- Output values in a given cycle reflect that cycle's counter (flops are loaded from next-state):
  - clk_out = (counter < high_act).
  - tick = (counter == div_act-1).
  - high_act = 0 gives constant low; high_act = div_act gives constant high. tick runs in both cases.
- Config handshake:
  - Transfer occurs when cfg_valid and cfg_ready are both high.
  - Legal config: cfg_div >= 2 and cfg_high <= cfg_div.
  - Illegal config: consumed, cfg_err = 1 for the following cycle, no other state change.
  - Legal config: latched to shadow; pending = 1 and cfg_ready = 0 from the next cycle.
- Application of a pending config:
  - RUN: applied at the wrap cycle (counter == div_act-1). The next cycle has counter = 0 with the new div/high.
  - IDLE: applied the cycle after acceptance.
  - After application, pending = 0 and cfg_ready = 1 on the following cycle.
- Simultaneous events:
  - Acceptance in the same cycle as a wrap: not applied at that wrap; waits for the next one.
  - en falls while pending: go to IDLE, then apply the shadow the following cycle.
- Counter update: counter + 1 with no overflow possible, since counter < div_act <= 2^WIDTH-1.

Decomposition:
- Package clk_pkg: state encoding (IDLE, RUN), WIDTH default, legality-check function.
- Sub-module clk_div_core: counter plus compare, with inputs div/high/run/load and outputs clk_out/tick/wrap.
- clk_div_ctrl owns the FSM, handshake and shadow registers.

Test Plan:
- Reset with DEFAULT_DIV = 10, DEFAULT_HIGH = 5, en = 1 -> clk_out is 5 high then 5 low, repeating; tick pulses every 10th cycle, coincident with the last low cycle.
- Load div = 4, high = 1 while counter = 3 -> current 10-cycle period completes unchanged. Next period is 1 high, 3 low. pending is high from acceptance until the wrap; cfg_ready = 0 meanwhile.
- Offer div = 1 or high = 7/div = 6 -> cfg_err pulses once, pending stays 0, waveform unchanged.
- Accept a config exactly on the wrap cycle -> old period repeats once more; new config applies at the following wrap.
- en = 0 mid-high with a config pending -> clk_out low next cycle; config applied in IDLE; en = 1 starts a new period at counter 0 with the new config.
- Assert rst_n = 0 mid-period with a config pending -> all outputs go to reset values immediately; after release, DEFAULT period resumes and the shadow is gone.
